// File: rtl/apb_master.sv
// APB3 initiator: one valid/ready command in, one SETUP/ACCESS transfer out, one response pulse back.
// Optional ACCESS wait-state timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ACCESS: begin
        if (PREADY) begin
          // Completion: a slave answering on the last allowed wait cycle still wins.
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          state_d     = IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == LAST_WAIT) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Bus controls are pure decodes of the state flop, so reset clears them immediately.
  assign cmd_ready = (state_q == IDLE);
  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master.md
# apb_master

APB3 initiator that turns single-command requests from an on-chip controller into APB transfers. It drives the bus side that `timer_top` and other APB peripherals respond to. It runs one transfer at a time: a valid/ready command port in, the APB SETUP/ACCESS sequence on the bus, and a one-cycle response pulse carrying read data and error status back out.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of PADDR and cmd_addr
- DATA_WIDTH, 8, width of PWDATA, PRDATA, cmd_wdata, rsp_rdata
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; must be ≥1; used only with APB_MASTER_TIMEOUT_EN

Ports:
- PCLK  in  1  clock; all logic on the rising edge
- PRESET_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on reads, 0 on writes
- rsp_err  out  1  PSLVERR seen or timeout; valid with rsp_valid
- rsp_timeout  out  1  transfer aborted by timeout; valid with rsp_valid
- PSEL, PENABLE, PWRITE  out  1 each  APB controls
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. Reset puts it in IDLE.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On handshake, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, cmd_ready=0.
  - Always lasts exactly one cycle, then goes to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1, cmd_ready=0.
  - Stays while PREADY=0.
  - When PREADY=1 is sampled: capture PRDATA (reads only) and PSLVERR, pulse rsp_valid on the next cycle, and return to IDLE.
- PSLVERR is sampled only when PREADY=1 in ACCESS and is ignored in every other cycle. rsp_err equals the sampled PSLVERR.
- PADDR, PWRITE and PWDATA are held constant from SETUP through the end of ACCESS. After the transfer they keep their last values.
- PWDATA is latched from cmd_wdata even for reads. The value is don't-care on the bus.
- cmd_* inputs are ignored outside IDLE. There is no queueing.
- rsp_valid has no backpressure. The consumer must take it in that cycle.
- Reset asserted mid-transfer: the FSM returns to IDLE at once, all outputs go to their reset values, and no rsp_valid is produced for the aborted transfer.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- All outputs are registered. None depends combinationally on inputs.
- Handshake in cycle N gives:
  - SETUP in cycle N+1.
  - ACCESS starting in cycle N+2.
  - With zero wait states (PREADY=1 in N+2): IDLE plus rsp_valid in N+3.
- Each PREADY=0 cycle in ACCESS adds one cycle of latency.
- The cycle carrying rsp_valid is already IDLE with cmd_ready=1. A new command accepted in that cycle reaches SETUP in the next cycle.
  - Back-to-back throughput is therefore 3 cycles per transfer.
- rsp_rdata, rsp_err and rsp_timeout keep their values until the next rsp_valid.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES and PREADY is still 0, the transfer aborts: PSEL=0 and PENABLE=0 on the next cycle, state IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in the cycle the count reaches the limit wins: the transfer completes normally.
- APB_MASTER_TIMEOUT_EN not defined:
  - There is no counter. ACCESS waits for PREADY indefinitely.
  - rsp_timeout is tied to 0.

## Test plan
- Write, no wait states: cmd write addr 0x00 data 0x5A, PREADY=1 → PSEL in N+1, PENABLE in N+2, PWDATA=0x5A; rsp_valid in N+3 with rsp_err=0.
- Read, 2 wait states: cmd read addr 0x02, PREADY low for 2 ACCESS cycles then high with PRDATA=0xC3 → ACCESS lasts 3 cycles, PADDR stays stable; rsp_valid in N+5 with rsp_rdata=0xC3.
- Slave error: read to addr 0xFF, PREADY=1 and PSLVERR=1 → rsp_err=1, rsp_timeout=0. PSLVERR pulsed during SETUP on a separate transfer is ignored.
- Timeout (macro on, TIMEOUT_CYCLES=4): PREADY held 0 → abort after 4 wait cycles, PSEL drops, rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0. With the macro off, the bus stays in ACCESS for 100 cycles with no rsp_valid.
- Back-to-back: cmd_valid held high with two commands, write 0x01=0x10 then read 0x01 → second SETUP one cycle after the first rsp_valid, 3-cycle spacing between transfers.
- Reset mid-ACCESS: assert PRESET_n low during a wait state → PSEL, PENABLE and rsp_valid go to 0 at once. After release cmd_ready=1 and no stale response appears.
